p_hit_feeder: RTL
=================

# p_hit_feeder

Write-side front end for the `p_hit` stage. Pops one ray/triangle record from an upstream first-word-fall-through FIFO. Holds the record in a register stage and writes it into each of the four `p_hit` input FIFOs, honouring each branch's `full` independently. A record is released only after all four branches have accepted it, which keeps the downstream FIFOs record-aligned. Sustains one record per cycle when no branch is full.

## Interface
- DATA_WIDTH, 32, width of each signed vector component
- CNT_WIDTH, 16, width of the issued-record counter
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_tri_normal_1[2:0]  in  DATA_WIDTH each  upstream record: normal row 0 [x,y,z]
- in_tri_normal_2[2:0]  in  DATA_WIDTH each  upstream record: normal row 1
- in_v0[2:0]  in  DATA_WIDTH each  upstream record: triangle vertex 0
- in_origin[2:0]  in  DATA_WIDTH each  upstream record: ray origin
- in_dir[2:0]  in  DATA_WIDTH each  upstream record: ray direction
- in_empty  in  1  upstream FIFO empty; data valid when low
- in_rd_en  out  1  upstream pop; record consumed on this cycle's rising edge
- out_tri_normal_1[2:0], out_tri_normal_2[2:0], out_v0[2:0], out_origin[2:0], out_dir[2:0]  out  DATA_WIDTH each  held record, fanned to all branches
- out_full[3:0]  in  1 each  per-branch full. Branch 0: p_hit_1 port 0. Branch 1: p_hit_1 port 1. Branch 2: dir FIFO. Branch 3: origin FIFO.
- out_wr_en[3:0]  out  1 each  per-branch write enable
- busy  out  1  a record is held with at least one branch pending
- issued_count  out  CNT_WIDTH  records fully delivered since reset; wraps

## Operation
- State: `hold` (all record fields), `pending[3:0]`.
- `busy = |pending`.
- EMPTY state: `pending == 0`. HOLD state: `pending != 0`.
- `out_wr_en[i] = pending[i] & ~out_full[i]` (combinational).
  - On each edge, `pending[i]` clears when `out_wr_en[i]` is high.
- `last = (pending & out_full) == 0`. This means every still-pending branch is written this cycle, or nothing is pending.
- `in_rd_en = ~in_empty & last`.
  - When `in_rd_en` is high: `hold <= in_*` and `pending <= 4'b1111`.
  - This overrides the per-bit clears, so back-to-back records are supported.
- `issued_count` increments on any edge where `pending != 0` and `last`, i.e. the final outstanding branch accepts. Wraps from 2^CNT_WIDTH-1 to 0.
- `out_*` data always reflects `hold`. Branches sample it only when their `out_wr_en` is high.
- Branches are independent. A full branch never blocks writes to non-full branches. An accepted branch is never written twice for the same record.
- Data is passed through unchanged; no arithmetic, no sign or width change.

## Timing
- Reset: the following are asserted immediately and asynchronously, without waiting for a clock:
  - `pending = 0`, `hold = 0`, `issued_count = 0`
  - therefore `out_wr_en = 0`, `busy = 0`, `in_rd_en = ~in_empty`, all `out_*` data = 0
- Latency: record popped at edge N; `out_wr_en` is high during cycle N+1 for every non-full branch.
- Throughput: 1 record/cycle with all `out_full` low and `in_empty` low.
- Reset deasserted with `in_empty` low: first pop on the first edge after release.
- Partial acceptance: the record is held and only the unaccepted branches are retried, until all four are accepted.
- `out_full[i]` toggling while `pending[i]` is set: the write fires in the first cycle where it is low.
- `in_empty` high with `last` true: `pending` drains to 0 and the block idles. `in_rd_en` stays low.
- Reset mid-record: the record is dropped with no further writes. Upstream is not rewound.

## Test plan
- Streaming, no backpressure: 8 records with origin x = 1..8, all full=0. Expect:
  - `in_rd_en` high for 8 consecutive cycles
  - `out_wr_en = 4'b1111` for 8 consecutive cycles, starting one cycle after the first pop
  - `issued_count = 8`
- Single-branch stall: `out_full[2] = 1` for 3 cycles after a pop. Expect:
  - `out_wr_en = 4'b1011`, then `4'b0000` ×2, then `4'b0100` when full drops
  - `in_rd_en` low throughout the stall; exactly one write per branch
- Staggered fulls: branch i full for i cycles. Expect each branch written exactly once, at cycle i after the pop; `issued_count` +1 only after branch 3 accepts.
- Back-to-back with last-branch release: hold the second record in upstream while branch 1 stalls. Expect `in_rd_en` high in the same cycle branch 1's write fires, and the new record on the outputs the next cycle.
- Async reset mid-record (`pending = 4'b0110`): expect `out_wr_en = 0`, `busy = 0`, `issued_count = 0` before the next clock edge, and no writes after release until a new pop.
- Counter wrap with CNT_WIDTH=4: 17 records -> `issued_count = 1`.

Source files
------------

// File: rtl/p_hit_feeder.sv
// -----------------------------------------------------------------------------
// p_hit_feeder
//
// Write-side front end for the p_hit stage. Each record popped from the
// upstream first-word-fall-through FIFO is held in a register stage and
// written once into each of four downstream FIFOs. Every branch honours its
// own full flag. The next record is popped only in the cycle where the last
// outstanding branch accepts the current one, so the four downstream FIFOs
// always hold the same sequence of records. With no back-pressure the block
// moves one record per clock.
//
// Parameters
//   DATA_WIDTH    width of each signed vector component
//   CNT_WIDTH     width of the issued-record counter
//
// Ports
//   clock                  rising-edge clock
//   reset                  asynchronous, active-high reset
//   in_tri_normal_1[2:0]   upstream record: normal row 0 [x,y,z]
//   in_tri_normal_2[2:0]   upstream record: normal row 1
//   in_v0[2:0]             upstream record: triangle vertex 0
//   in_origin[2:0]         upstream record: ray origin
//   in_dir[2:0]            upstream record: ray direction
//   in_empty               upstream FIFO empty (data valid when low)
//   in_rd_en               upstream pop, consumed on this rising edge
//   out_*[2:0]             held record, fanned out to all four branches
//   out_full[3:0]          per-branch full:
//                            0 = p_hit_1 port 0, 1 = p_hit_1 port 1,
//                            2 = dir FIFO,       3 = origin FIFO
//   out_wr_en[3:0]         per-branch write enable
//   busy                   a record is held with at least one branch pending
//   issued_count           records fully delivered since reset (wraps)
// -----------------------------------------------------------------------------
module p_hit_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clock,
  input  logic                         reset,

  input  logic signed [DATA_WIDTH-1:0] in_tri_normal_1 [2:0],
  input  logic signed [DATA_WIDTH-1:0] in_tri_normal_2 [2:0],
  input  logic signed [DATA_WIDTH-1:0] in_v0           [2:0],
  input  logic signed [DATA_WIDTH-1:0] in_origin       [2:0],
  input  logic signed [DATA_WIDTH-1:0] in_dir          [2:0],
  input  logic                         in_empty,
  output logic                         in_rd_en,

  output logic signed [DATA_WIDTH-1:0] out_tri_normal_1 [2:0],
  output logic signed [DATA_WIDTH-1:0] out_tri_normal_2 [2:0],
  output logic signed [DATA_WIDTH-1:0] out_v0           [2:0],
  output logic signed [DATA_WIDTH-1:0] out_origin       [2:0],
  output logic signed [DATA_WIDTH-1:0] out_dir          [2:0],
  input  logic [3:0]                   out_full,
  output logic [3:0]                   out_wr_en,

  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         issued_count
);

  // ---------------------------------------------------------------------------
  // Branch bookkeeping
  // ---------------------------------------------------------------------------
  // pending_reg[i] is set while branch i still owes a write of the held record.
  logic [3:0]           pending_reg;
  logic [3:0]           pending_next;
  logic                 last;
  logic                 load;
  logic [CNT_WIDTH-1:0] issued_count_reg;

  always_comb begin
    out_wr_en = pending_reg & ~out_full;
    // True when no pending branch is blocked: either everything outstanding
    // is written this cycle, or nothing is outstanding at all.
    last      = ((pending_reg & out_full) == 4'b0000);
    load      = ~in_empty & last;
    // A fresh load re-arms all four branches and takes precedence over the
    // per-branch clears; this is what allows back-to-back records.
    if (load) begin
      pending_next = 4'b1111;
    end else begin
      pending_next = pending_reg & ~out_wr_en;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_reg <= 4'b0000;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // A record counts as delivered on the edge where its final branch accepts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_count_reg <= '0;
    end else if ((pending_reg != 4'b0000) && last) begin
      issued_count_reg <= issued_count_reg + CNT_WIDTH'(1);
    end
  end

  assign in_rd_en     = load;
  assign busy         = |pending_reg;
  assign issued_count = issued_count_reg;

  // ---------------------------------------------------------------------------
  // Record hold stage, one slice per vector component
  // ---------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] tri_normal_1_reg [2:0];
  logic signed [DATA_WIDTH-1:0] tri_normal_2_reg [2:0];
  logic signed [DATA_WIDTH-1:0] v0_reg           [2:0];
  logic signed [DATA_WIDTH-1:0] origin_reg       [2:0];
  logic signed [DATA_WIDTH-1:0] dir_reg          [2:0];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_comp
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          tri_normal_1_reg[gi] <= '0;
          tri_normal_2_reg[gi] <= '0;
          v0_reg[gi]           <= '0;
          origin_reg[gi]       <= '0;
          dir_reg[gi]          <= '0;
        end else if (load) begin
          tri_normal_1_reg[gi] <= in_tri_normal_1[gi];
          tri_normal_2_reg[gi] <= in_tri_normal_2[gi];
          v0_reg[gi]           <= in_v0[gi];
          origin_reg[gi]       <= in_origin[gi];
          dir_reg[gi]          <= in_dir[gi];
        end
      end

      // The held record is presented continuously; each branch samples it
      // only when its own write enable is high.
      assign out_tri_normal_1[gi] = tri_normal_1_reg[gi];
      assign out_tri_normal_2[gi] = tri_normal_2_reg[gi];
      assign out_v0[gi]           = v0_reg[gi];
      assign out_origin[gi]       = origin_reg[gi];
      assign out_dir[gi]          = dir_reg[gi];
    end
  endgenerate

endmodule
